fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `control_unit`. It owns the program counter, issues requests to instruction memory, latches the returned 18-bit word into an instruction register, and presents it to `control_unit` on `ins` with a valid/take handshake. It accepts branch and jump redirects from `control_unit` via `pc_enable`/`pc_select`/`br_addr`.

---
 rtl/fetch_unit.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding control_unit.
// It owns the program counter, requests words from instruction memory,
// latches each returned word into the instruction register, and presents it
// on ins/ins_pc with ins_valid.
//
// Optional feature macro: FETCH_PREFETCH_EN
//   When defined, a one-entry prefetch buffer keeps requesting while an
//   instruction is waiting to be taken. This allows back-to-back delivery.
//
// Handshakes:
//   imem: imem_req/imem_addr are held until imem_ack is seen while imem_req=1.
//         A redirect may move imem_addr. A word is accepted only on
//         imem_req & imem_ack. Zero-wait (ack in the request cycle) is legal.
//   ins:  ins/ins_pc are stable while ins_valid=1 until ins_take. A transfer
//         happens on ins_valid & ins_take. ins_take is ignored while
//         ins_valid=0. A redirect in the same cycle wins, and the current ins
//         counts as consumed.
//
// All outputs decode flops only; no input reaches an output combinationally.
module fetch_unit #(
  parameter int              PC_W     = 10,
  parameter int              INS_W    = 18,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [INS_W-1:0] imem_data,
  output logic [INS_W-1:0] ins,
  output logic [PC_W-1:0]  ins_pc,
  output logic             ins_valid,
  input  logic             ins_take,
  input  logic             pc_enable,
  input  logic             pc_select,
  input  logic [PC_W-1:0]  br_addr,
  output logic [1:0]       dbg_state
);

  // IDLE: after reset. REQ: fetching with no live instruction.
  // HOLD: an instruction is live on ins.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic [INS_W-1:0]   ins_q, ins_d;
  logic [PC_W-1:0]    ins_pc_q, ins_pc_d;

`ifdef FETCH_PREFETCH_EN
  logic [INS_W-1:0]   buf_q, buf_d;
  logic [PC_W-1:0]    buf_pc_q, buf_pc_d;
  logic               buf_full_q, buf_full_d;
`endif

  logic redirect;
  logic ack_fire;
  logic take;

  // A branch or jump target arrives only when both strobes are high.
  // Sequential increment is internal, so pc_select=0 has no effect.
  assign redirect = pc_enable & pc_select;
  assign ack_fire = imem_req & imem_ack;
  assign take     = ins_valid & ins_take;

  // State and datapath registers, with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      ins_q      <= '0;
      ins_pc_q   <= '0;
`ifdef FETCH_PREFETCH_EN
      buf_q      <= '0;
      buf_pc_q   <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ins_q      <= ins_d;
      ins_pc_q   <= ins_pc_d;
`ifdef FETCH_PREFETCH_EN
      buf_q      <= buf_d;
      buf_pc_q   <= buf_pc_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

  // Next-state logic. A redirect always restarts fetching in REQ.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (ack_fire) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (take) begin
`ifdef FETCH_PREFETCH_EN
          // Stay live if a replacement word is available this cycle.
          if (!buf_full_q && !ack_fire) begin
            state_d = ST_REQ;
          end
`else
          state_d = ST_REQ;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    imem_req  = 1'b0;
    ins_valid = 1'b0;
    case (state_q)
      ST_REQ: imem_req = 1'b1;
      ST_HOLD: begin
        ins_valid = 1'b1;
`ifdef FETCH_PREFETCH_EN
        // Keep fetching ahead until the prefetch slot is occupied.
        imem_req  = ~buf_full_q;
`endif
      end
      default: ;
    endcase
  end

  // Datapath next values: PC advance, instruction register and prefetch slot loads.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    ins_d      = ins_q;
    ins_pc_d   = ins_pc_q;
`ifdef FETCH_PREFETCH_EN
    buf_d      = buf_q;
    buf_pc_d   = buf_pc_q;
    buf_full_d = buf_full_q;
`endif
    if (redirect) begin
      // Any same-cycle ack is dropped. The PC wraps naturally at 2^PC_W.
      fetch_pc_d = br_addr;
`ifdef FETCH_PREFETCH_EN
      buf_full_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_REQ: begin
          if (ack_fire) begin
            ins_d      = imem_data;
            ins_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_ONE;
          end
        end
`ifdef FETCH_PREFETCH_EN
        ST_HOLD: begin
          if (take) begin
            // The buffered word is older than any in-flight ack,
            // so it goes first.
            if (buf_full_q) begin
              ins_d      = buf_q;
              ins_pc_d   = buf_pc_q;
              buf_full_d = 1'b0;
            end else if (ack_fire) begin
              ins_d      = imem_data;
              ins_pc_d   = fetch_pc_q;
              fetch_pc_d = fetch_pc_q + PC_ONE;
            end
          end else if (ack_fire) begin
            buf_d      = imem_data;
            buf_pc_d   = fetch_pc_q;
            buf_full_d = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_ONE;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign imem_addr = fetch_pc_q;
  assign ins       = ins_q;
  assign ins_pc    = ins_pc_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: a memory model with random wait states, directed
// scenarios, and a randomized phase. A monitor checks protocol timing and
// scoreboards delivered words against program order.
module tb_fetch_unit;

  localparam int              PC_W     = 10;
  localparam int              INS_W    = 18;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [INS_W-1:0] imem_data;
  logic [INS_W-1:0] ins;
  logic [PC_W-1:0]  ins_pc;
  logic             ins_valid;
  logic             ins_take;
  logic             pc_enable;
  logic             pc_select;
  logic [PC_W-1:0]  br_addr;
  logic [1:0]       dbg_state;

  fetch_unit #(.PC_W(PC_W), .INS_W(INS_W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .ins(ins), .ins_pc(ins_pc), .ins_valid(ins_valid),
    .ins_take(ins_take), .pc_enable(pc_enable), .pc_select(pc_select),
    .br_addr(br_addr), .dbg_state(dbg_state)
  );

  // ---------------- reference state ----------------
  logic [INS_W-1:0] mem [0:1023];   // program image
  logic [PC_W-1:0]  exp_q[$];       // next expected delivered address (program order)
  int n_pass  = 0;
  int n_total = 0;
  int wait_mode = 0;                // <0: random 0..3 wait cycles, else fixed

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- driver tasks ----------------
  // Advance to the drive point of the next cycle (2 time units after negedge).
  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; ins_take = 1'b0; pc_enable = 1'b0; pc_select = 1'b0;
    exp_q.delete();
    exp_q.push_back(RESET_PC);
    cyc(n);
    rst = 1'b0;
  endtask

  task automatic do_redirect(input logic [PC_W-1:0] tgt);
    pc_enable = 1'b1; pc_select = 1'b1; br_addr = tgt;
    exp_q.delete();
    exp_q.push_back(tgt);
    cyc(1);
    pc_enable = 1'b0; pc_select = 1'b0;
  endtask

  task automatic take_one();
    ins_take = 1'b1;
    cyc(1);
    ins_take = 1'b0;
  endtask

  task automatic wait_valid(input int lim, input string name);
    int k;
    k = 0;
    while (!ins_valid && k < lim) begin
      cyc(1);
      k++;
    end
    chk(name, ins_valid, 1);
  endtask

  // ---------------- memory model ----------------
  initial begin : mem_model
    int              wait_left;
    logic            pending;
    logic [PC_W-1:0] last_addr;
    wait_left = 0; pending = 1'b0; last_addr = '0;
    imem_ack = 1'b0; imem_data = '0;
    forever begin
      @(negedge clk);
      #3;
      if (rst || !imem_req) begin
        imem_ack  = 1'b0;
        imem_data = INS_W'($urandom);
        pending   = 1'b0;
      end else begin
        if (!pending || imem_addr != last_addr) begin
          pending   = 1'b1;
          last_addr = imem_addr;
          wait_left = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
        end
        if (wait_left == 0) begin
          imem_ack  = 1'b1;
          imem_data = mem[imem_addr];
          pending   = 1'b0;
        end else begin
          imem_ack  = 1'b0;
          imem_data = INS_W'($urandom);
          wait_left--;
        end
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct {
    logic             rst, req, ack, valid, take, en, sel;
    logic [PC_W-1:0]  addr, ipc, br;
    logic [INS_W-1:0] data, iw;
  } snap_t;

  initial begin : monitor
    snap_t           p, s;
    bit              have_p;
    int              since_rst;
    logic [PC_W-1:0] e;
    have_p = 1'b0; since_rst = 100;
    forever begin
      @(negedge clk);
      #4;  // one unit before the rising edge: inputs applied, outputs settled
      s.rst = rst;       s.req = imem_req;   s.ack = imem_ack;   s.valid = ins_valid;
      s.take = ins_take; s.en = pc_enable;   s.sel = pc_select;  s.addr = imem_addr;
      s.ipc = ins_pc;    s.br = br_addr;     s.data = imem_data; s.iw = ins;
      if (s.rst) since_rst = 0;
      else since_rst++;

      if (have_p) begin
        if (p.rst) begin
          chk("rst_req", s.req, 0);
          chk("rst_valid", s.valid, 0);
          chk("rst_ins", s.iw, 0);
          chk("rst_ins_pc", s.ipc, 0);
        end else if (p.en && p.sel) begin
          chk("redir_req", s.req, 1);
          chk("redir_addr", s.addr, p.br);
          chk("redir_valid", s.valid, 0);
        end else begin
          if (p.req && !p.ack) begin
            chk("req_hold", s.req, 1);
            chk("addr_stable", s.addr, p.addr);
          end
          if (p.valid && !p.take) begin
            chk("valid_hold", s.valid, 1);
            chk("ins_hold", s.iw, p.iw);
            chk("ins_pc_hold", s.ipc, p.ipc);
          end
          if (!p.valid && !(p.req && p.ack)) begin
            chk("idle_valid", s.valid, 0);
            chk("idle_ins", s.iw, p.iw);
            chk("idle_ins_pc", s.ipc, p.ipc);
          end
`ifndef FETCH_PREFETCH_EN
          if (p.req && p.ack) begin
            chk("load_valid", s.valid, 1);
            chk("load_ins", s.iw, p.data);
            chk("load_ins_pc", s.ipc, p.addr);
          end
          if (p.valid && p.take) begin
            chk("take_req", s.req, 1);
            chk("take_valid", s.valid, 0);
          end
`endif
        end
        if (since_rst == 2 && !(p.en && p.sel)) begin
          chk("start_req", s.req, 1);
          chk("start_addr", s.addr, RESET_PC);
        end
`ifndef FETCH_PREFETCH_EN
        chk("req_valid_excl", s.req & s.valid, 0);
`endif
      end

      // Delivered word: must be the next address in program order.
      if (s.valid && s.take && !s.rst && !(s.en && s.sel)) begin
        if (exp_q.size() == 0) begin
          chk("sb_nonempty", 0, 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_ins_pc", s.ipc, e);
          chk("sb_ins", s.iw, mem[e]);
          exp_q.push_back(e + PC_W'(1));
        end
      end
      p = s;
      have_p = 1'b1;
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int r;
    int n;
    int k;
    rst = 1'b1; ins_take = 1'b0; pc_enable = 1'b0; pc_select = 1'b0; br_addr = '0;
    for (int i = 0; i < 1024; i++) mem[i] = INS_W'($urandom);
    mem[1] = 18'h2A5C5;

    // Reset with zero-wait memory.
    wait_mode = 0;
    do_reset(3);
    chk("c0_req", imem_req, 0);
    chk("c0_valid", ins_valid, 0);
    chk("c0_ins", ins, 0);
    cyc(1);
    chk("c1_req", imem_req, 1);
    chk("c1_addr", imem_addr, RESET_PC);
    cyc(1);
    chk("c2_valid", ins_valid, 1);
    chk("c2_ins_pc", ins_pc, 0);
    cyc(3);
    wait_mode = 3;
    take_one();

    // Three wait cycles on address 1.
    n = 0; k = 0;
    while (!ins_valid && k < 20) begin
      if (imem_req) n++;
      cyc(1);
      k++;
    end
    chk("b_req_cycles", n, 4);
    chk("b_ins", ins, 18'h2A5C5);
    chk("b_ins_pc", ins_pc, 1);
    cyc(4);
    chk("b_hold_valid", ins_valid, 1);
    chk("b_hold_ins", ins, 18'h2A5C5);
    wait_mode = 0;
    take_one();

    // Redirect coinciding with a zero-wait ack.
    chk("c_req", imem_req, 1);
    do_redirect(10'h155);
    chk("c_addr", imem_addr, 10'h155);
    chk("c_valid0", ins_valid, 0);
    wait_valid(20, "c_valid");
    chk("c_ins_pc", ins_pc, 10'h155);
    take_one();

    // Wrap-around from the top of the address space.
    do_redirect(10'h3FF);
    wait_valid(20, "d_valid1");
    chk("d_pc1", ins_pc, 10'h3FF);
    take_one();
    wait_valid(20, "d_valid2");
    chk("d_pc2", ins_pc, 10'h000);
    take_one();

    // Reset while a request is outstanding.
    wait_mode = 2;
    cyc(1);
    chk("e_req_pending", imem_req, 1);
    do_reset(1);
    chk("e_req", imem_req, 0);
    chk("e_valid", ins_valid, 0);
    cyc(1);
    chk("e_restart_req", imem_req, 1);
    chk("e_restart_addr", imem_addr, RESET_PC);
    wait_mode = 0;
    wait_valid(20, "e_valid2");
    chk("e_ins_pc", ins_pc, RESET_PC);
    take_one();

`ifdef FETCH_PREFETCH_EN
    // Back-to-back delivery with take held high, then a flush.
    ins_take = 1'b1;
    wait_valid(20, "g_first");
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk("g_stream_valid", ins_valid, 1);
    end
    do_redirect(10'h010);
    wait_valid(20, "g_flush_valid");
    chk("g_flush_pc", ins_pc, 10'h010);
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("g_stream2_valid", ins_valid, 1);
    end
    ins_take = 1'b0;
    cyc(2);
`endif

    // Randomized traffic.
    wait_mode = -1;
    for (int i = 0; i < 3000; i++) begin
      ins_take  = ($urandom_range(0, 99) < 60);
      pc_enable = 1'b0;
      pc_select = 1'b0;
      br_addr   = PC_W'($urandom);
      r = $urandom_range(0, 299);
      if (r == 0) begin
        rst = 1'b1;
        exp_q.delete();
        exp_q.push_back(RESET_PC);
      end else if (r < 16) begin
        pc_enable = 1'b1;
        pc_select = 1'b1;
        if (r < 4) br_addr = 10'h3FF;
        exp_q.delete();
        exp_q.push_back(br_addr);
      end else if (r < 24) begin
        pc_enable = 1'b1;
      end else if (r < 30) begin
        pc_select = 1'b1;
      end
      cyc(1);
      rst = 1'b0;
    end
    ins_take = 1'b0; pc_enable = 1'b0; pc_select = 1'b0;
    cyc(5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
